// File: rtl/bios_boot_loader.sv
// Boot-copy sequencer: copies COPY_LEN BIOS ROM words into instruction memory, then releases the CPU.
// Optional BOOT_HLT_STOP_EN: an accepted word with opcode bits [31:26] == 6'b011101 ends the copy early.
module bios_boot_loader #(
    parameter int          COPY_LEN  = 64,
    parameter logic [31:0] IMEM_BASE = 32'h0
) (
    input  logic        clk_auto,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] bios_addr,
    input  logic [31:0] bios_data,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic        imem_ready,
    output logic        busy,
    output logic        done,
    output logic        cpu_reset_n,
    output logic [6:0]  words_copied
);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WRITE, DONE} state_t;

    localparam logic [6:0] LAST_IDX = 7'(COPY_LEN - 1);

    state_t      state_q;
    logic [6:0]  idx_q;
    logic [31:0] bios_addr_q;
    logic        imem_we_q;
    logic [31:0] imem_addr_q;
    logic [31:0] imem_wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        cpu_reset_n_q;
    logic [6:0]  words_copied_q;
    logic        last_word;

    // The word held in imem_wdata_q is the one being accepted, so the halt test looks there.
`ifdef BOOT_HLT_STOP_EN
    localparam logic [5:0] HLT_OP = 6'b011101;
    assign last_word = (idx_q == LAST_IDX) || (imem_wdata_q[31:26] == HLT_OP);
`else
    assign last_word = (idx_q == LAST_IDX);
`endif

    always_ff @(posedge clk_auto or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            bios_addr_q    <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cpu_reset_n_q  <= 1'b0;
            words_copied_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        idx_q          <= '0;
                        bios_addr_q    <= '0;
                        words_copied_q <= '0;
                        cpu_reset_n_q  <= 1'b0;
                        done_q         <= 1'b0;
                        busy_q         <= 1'b1;
                        state_q        <= FETCH;
                    end
                end
                FETCH: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    imem_wdata_q <= bios_data;
                    imem_addr_q  <= IMEM_BASE + {25'd0, idx_q};
                    imem_we_q    <= 1'b1;
                    state_q      <= WRITE;
                end
                WRITE: begin
                    if (imem_ready) begin
                        imem_we_q      <= 1'b0;
                        words_copied_q <= words_copied_q + 7'd1;
                        if (last_word) begin
                            busy_q        <= 1'b0;
                            done_q        <= 1'b1;
                            cpu_reset_n_q <= 1'b1;
                            state_q       <= DONE;
                        end else begin
                            idx_q       <= idx_q + 7'd1;
                            bios_addr_q <= {25'd0, idx_q + 7'd1};
                            state_q     <= FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bios_addr    = bios_addr_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cpu_reset_n  = cpu_reset_n_q;
    assign words_copied = words_copied_q;

endmodule

// File: tb/tb_bios_boot_loader.sv
// Scoreboard bench for bios_boot_loader: a 4-word copy at base 0x100 and a 64-word copy with a hlt word at index 22.
module tb_bios_boot_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

`ifdef BOOT_HLT_STOP_EN
    localparam int NB = 23;
`else
    localparam int NB = 64;
`endif

    logic        clk_auto = 1'b0;
    logic        rst_n    = 1'b1;
    logic        start_a  = 1'b0;
    logic        ready_a  = 1'b1;
    logic        start_b  = 1'b0;
    logic        ready_b  = 1'b1;

    logic [31:0] bios_addr_a, bios_data_a, imem_addr_a, imem_wdata_a;
    logic        imem_we_a, busy_a, done_a, cpu_reset_n_a;
    logic [6:0]  words_copied_a;
    logic [31:0] bios_addr_b, bios_data_b, imem_addr_b, imem_wdata_b;
    logic        imem_we_b, busy_b, done_b, cpu_reset_n_b;
    logic [6:0]  words_copied_b;

    logic [31:0] romA [64];
    logic [31:0] romB [64];
    wr_t         qa[$];
    wr_t         qb[$];
    int          cyc = 0;
    int          testsRun = 0;
    int          failCount = 0;
    int          s;

    bios_boot_loader #(.COPY_LEN(4), .IMEM_BASE(32'h100)) dutA (
        .clk_auto(clk_auto), .rst_n(rst_n), .start(start_a),
        .bios_addr(bios_addr_a), .bios_data(bios_data_a),
        .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
        .imem_ready(ready_a), .busy(busy_a), .done(done_a),
        .cpu_reset_n(cpu_reset_n_a), .words_copied(words_copied_a)
    );

    bios_boot_loader #(.COPY_LEN(64), .IMEM_BASE(32'h0)) dutB (
        .clk_auto(clk_auto), .rst_n(rst_n), .start(start_b),
        .bios_addr(bios_addr_b), .bios_data(bios_data_b),
        .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
        .imem_ready(ready_b), .busy(busy_b), .done(done_b),
        .cpu_reset_n(cpu_reset_n_b), .words_copied(words_copied_b)
    );

    always #5 clk_auto = ~clk_auto;

    always @(posedge clk_auto) cyc <= cyc + 1;

    // Registered-output ROM models: data appears one edge after the address is sampled.
    always @(posedge clk_auto) begin
        bios_data_a <= romA[bios_addr_a[5:0]];
        bios_data_b <= romB[bios_addr_b[5:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_auto);
        #1;
    endtask

    task automatic applyStimulus(input logic startA, input logic readyA);
        start_a = startA;
        ready_a = readyA;
    endtask

    // Expected writes for a 4-word copy; words from stallWord on slip by stallLen cycles.
    task automatic pushA(input int s0, input int stallWord, input int stallLen);
        wr_t w;
        for (int n = 0; n < 4; n++) begin
            w.addr = 32'h100 + n;
            w.data = romA[n];
            w.cyc  = s0 + 3 * n + 2 + ((n >= stallWord) ? stallLen : 0);
            qa.push_back(w);
        end
    endtask

    task automatic waitDone(input bit useB, input int expCyc, input string tag);
        int lim;
        lim = cyc + 400;
        while (!(useB ? done_b : done_a) && cyc < lim) tick();
        if (!(useB ? done_b : done_a)) checkOutput({tag, "Timeout"}, 32'd0, 32'd1);
        else checkOutput(tag, cyc, expCyc);
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, "We"},     {31'd0, imem_we_a}, 32'd0);
        checkOutput({tag, "Busy"},   {31'd0, busy_a}, 32'd0);
        checkOutput({tag, "Done"},   {31'd0, done_a}, 32'd0);
        checkOutput({tag, "CpuRst"}, {31'd0, cpu_reset_n_a}, 32'd0);
        checkOutput({tag, "Addr"},   imem_addr_a, 32'd0);
        checkOutput({tag, "Wdata"},  imem_wdata_a, 32'd0);
        checkOutput({tag, "BiosA"},  bios_addr_a, 32'd0);
        checkOutput({tag, "Words"},  {25'd0, words_copied_a}, 32'd0);
    endtask

    // Monitors: every accepted write pops the scoreboard; stalled writes must match the head unchanged.
    always @(negedge clk_auto) begin
        if (rst_n) begin
            checkOutput("busyDoneA", {31'd0, busy_a & done_a}, 32'd0);
            if (imem_we_a) begin
                if (qa.size() == 0) begin
                    checkOutput("unexpectedWriteA", imem_addr_a, 32'hFFFF_FFFF);
                end else if (ready_a) begin
                    checkOutput("wrAddrA", imem_addr_a, qa[0].addr);
                    checkOutput("wrDataA", imem_wdata_a, qa[0].data);
                    checkOutput("wrCycA", cyc, qa[0].cyc);
                    void'(qa.pop_front());
                end else begin
                    checkOutput("stallAddrA", imem_addr_a, qa[0].addr);
                    checkOutput("stallDataA", imem_wdata_a, qa[0].data);
                end
            end
        end
    end

    always @(negedge clk_auto) begin
        if (rst_n) begin
            checkOutput("busyDoneB", {31'd0, busy_b & done_b}, 32'd0);
            if (imem_we_b) begin
                if (qb.size() == 0) begin
                    checkOutput("unexpectedWriteB", imem_addr_b, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("wrAddrB", imem_addr_b, qb[0].addr);
                    checkOutput("wrDataB", imem_wdata_b, qb[0].data);
                    checkOutput("wrCycB", cyc, qb[0].cyc);
                    void'(qb.pop_front());
                end
            end
        end
    end

    initial begin
        wr_t w;
        for (int i = 0; i < 64; i++) begin
            romA[i] = 32'hCAFE_0000 ^ (i * 32'h0101_0101);
            romB[i] = 32'h1234_0000 + i;
        end
        romB[22] = 32'h7400_0016;

        #2 rst_n = 1'b0;
        #1 checkResetA("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkResetA("idle");

        // Plain 4-word copy with memory always ready.
        applyStimulus(1'b1, 1'b1);
        s = cyc + 1;
        pushA(s, 99, 0);
        tick();
        applyStimulus(1'b0, 1'b1);
        checkOutput("run1Busy", {31'd0, busy_a}, 32'd1);
        checkOutput("run1CpuRst", {31'd0, cpu_reset_n_a}, 32'd0);
        waitDone(1'b0, s + 12, "run1DoneCyc");
        checkOutput("run1Words", {25'd0, words_copied_a}, 32'd4);
        checkOutput("run1CpuRel", {31'd0, cpu_reset_n_a}, 32'd1);
        checkOutput("run1QEmpty", qa.size(), 32'd0);

        // Restart from DONE with a 5-cycle stall on word 1.
        applyStimulus(1'b1, 1'b1);
        s = cyc + 1;
        pushA(s, 1, 5);
        tick();
        applyStimulus(1'b0, 1'b1);
        checkOutput("run2CpuRst", {31'd0, cpu_reset_n_a}, 32'd0);
        checkOutput("run2Done", {31'd0, done_a}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        applyStimulus(1'b0, 1'b1);
        waitDone(1'b0, s + 17, "run2DoneCyc");
        checkOutput("run2Words", {25'd0, words_copied_a}, 32'd4);
        checkOutput("run2QEmpty", qa.size(), 32'd0);

        // start asserted while word 0 is in WRITE must be ignored.
        applyStimulus(1'b1, 1'b1);
        s = cyc + 1;
        pushA(s, 99, 0);
        tick();
        applyStimulus(1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1);
        waitDone(1'b0, s + 12, "run3DoneCyc");
        for (int i = 0; i < 4; i++) tick();
        checkOutput("run3Words", {25'd0, words_copied_a}, 32'd4);
        checkOutput("run3StillDone", {31'd0, done_a}, 32'd1);
        checkOutput("run3QEmpty", qa.size(), 32'd0);

        // Asynchronous reset while word 2 is pending.
        applyStimulus(1'b1, 1'b1);
        s = cyc + 1;
        pushA(s, 99, 0);
        tick();
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("run4Pending", {31'd0, imem_we_a}, 32'd1);
        checkOutput("run4PendAddr", imem_addr_a, 32'h102);
        rst_n = 1'b0;
        #1 checkResetA("midRst");
        qa.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checkResetA("postRst");
        applyStimulus(1'b1, 1'b1);
        s = cyc + 1;
        pushA(s, 99, 0);
        tick();
        applyStimulus(1'b0, 1'b1);
        waitDone(1'b0, s + 12, "run5DoneCyc");
        checkOutput("run5Words", {25'd0, words_copied_a}, 32'd4);
        checkOutput("run5QEmpty", qa.size(), 32'd0);

        // 64-word copy with a hlt word at index 22.
        start_b = 1'b1;
        s = cyc + 1;
        for (int n = 0; n < NB; n++) begin
            w.addr = n;
            w.data = romB[n];
            w.cyc  = s + 3 * n + 2;
            qb.push_back(w);
        end
        tick();
        start_b = 1'b0;
        waitDone(1'b1, s + 3 * NB, "runBDoneCyc");
        for (int i = 0; i < 4; i++) tick();
        checkOutput("runBWords", {25'd0, words_copied_b}, NB);
        checkOutput("runBCpuRel", {31'd0, cpu_reset_n_b}, 32'd1);
        checkOutput("runBQEmpty", qb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
